// File: rtl/dbgnoc_pkg.sv
// Shared debug-NoC definitions: flit types, trace header field layout and
// packetizer FSM state encodings.
package dbgnoc_pkg;

  localparam logic [1:0] FlitPayload = 2'b00;
  localparam logic [1:0] FlitHeader  = 2'b01;
  localparam logic [1:0] FlitLast    = 2'b10;
  localparam logic [1:0] FlitSingle  = 2'b11;

  // Header data field, MSB first: {dest, class, loss, len}
  localparam int unsigned HdrLenLsb     = 0;
  localparam int unsigned HdrLenWidth   = 7;
  localparam int unsigned HdrLossBit    = 7;
  localparam int unsigned HdrClassLsb   = 8;
  localparam int unsigned HdrClassWidth = 3;
  localparam int unsigned HdrDestLsb    = 11;
  localparam int unsigned HdrDestWidth  = 5;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeader = 2'd1;
  localparam logic [1:0] StPayHi  = 2'd2;
  localparam logic [1:0] StPayLo  = 2'd3;

endpackage

// File: rtl/dbgnoc_trace_fifo.sv
// Synchronous first-word-fall-through FIFO holding trace words; the head is
// always visible on rdata while the FIFO is non-empty.
module dbgnoc_trace_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/dbgnoc_trace_packetizer.sv
// Packetizes 32-bit trace words into header + hi/lo payload flits on the
// trace virtual channel, dropping and counting words that arrive when full.
module dbgnoc_trace_packetizer
  import dbgnoc_pkg::*;
#(
  parameter int unsigned DBG_NOC_FLIT_DATA_WIDTH = 16,
  parameter int unsigned DBG_NOC_FLIT_TYPE_WIDTH = 2,
  parameter int unsigned DBG_NOC_VCHANNELS       = 2,
  parameter int unsigned DBG_NOC_TRACE_VCHANNEL  = 1,
  parameter logic [4:0]  DEST_ID                 = 5'd0,
  parameter logic [2:0]  TRACE_CLASS             = 3'd1,
  parameter int unsigned FIFO_DEPTH              = 16,
  parameter int unsigned MAX_WORDS               = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                enable,
  input  logic [31:0]                                         trace_data,
  input  logic                                                trace_valid,
  output logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_FLIT_DATA_WIDTH-1:0] dbgnoc_out_flit,
  output logic [DBG_NOC_VCHANNELS-1:0]                        dbgnoc_out_valid,
  input  logic [DBG_NOC_VCHANNELS-1:0]                        dbgnoc_out_ready,
  output logic [15:0]                                         drop_count,
  output logic                                                busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      state_q, state_d;
  logic [6:0]      len_q, remaining_q, start_len;
  logic            loss_q, loss_pending_q;
  logic [15:0]     drop_count_q;

  logic [31:0]     fifo_head;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, pop, drop, out_valid, hs, start;
  logic            unused_ready;

  assign push      = trace_valid & ~fifo_full;
  assign drop      = trace_valid & fifo_full;
  assign out_valid = (state_q != StIdle);
  assign hs        = out_valid & dbgnoc_out_ready[DBG_NOC_TRACE_VCHANNEL];
  assign pop       = (state_q == StPayLo) & hs;
  assign start     = (state_q == StIdle) & (state_d == StHeader);

  assign unused_ready = ^dbgnoc_out_ready;

  dbgnoc_trace_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (trace_data),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    if (32'(fifo_count) > MAX_WORDS) start_len = 7'(MAX_WORDS);
    else                             start_len = 7'(fifo_count);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable && !fifo_empty) state_d = StHeader;
      StHeader: if (hs) state_d = StPayHi;
      StPayHi:  if (hs) state_d = StPayLo;
      StPayLo:  if (hs) state_d = (remaining_q > 7'd1) ? StPayHi : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      remaining_q    <= '0;
      loss_q         <= 1'b0;
      loss_pending_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        len_q       <= start_len;
        remaining_q <= start_len;
        loss_q      <= loss_pending_q;
      end else if (pop) begin
        remaining_q <= remaining_q - 7'd1;
      end
      // A drop in the same cycle as the reporting header keeps the flag set.
      if (drop) begin
        loss_pending_q <= 1'b1;
      end else if ((state_q == StHeader) && hs && loss_q) begin
        loss_pending_q <= 1'b0;
      end
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  always_comb begin
    dbgnoc_out_flit  = '0;
    dbgnoc_out_valid = '0;
    dbgnoc_out_valid[DBG_NOC_TRACE_VCHANNEL] = out_valid;
    unique case (state_q)
      StHeader: dbgnoc_out_flit = {FlitHeader, DEST_ID, TRACE_CLASS, loss_q, len_q};
      StPayHi:  dbgnoc_out_flit = {FlitPayload, fifo_head[31:16]};
      StPayLo:  dbgnoc_out_flit = {(remaining_q == 7'd1) ? FlitLast : FlitPayload,
                                   fifo_head[15:0]};
      default:  ;
    endcase
  end

  assign drop_count = drop_count_q;
  assign busy       = out_valid | ~fifo_empty;

endmodule
